uart_rx_controller: RTL and testbench
=====================================

// Module: uart_rx_controller
//
// PURPOSE
// Receive-side sequencer for the UART. Detects the start bit on the serial
// line, times every bit from an oversampled baud tick, shifts in WIDTH data
// bits LSB first, and pulses check_stop at mid stop bit. The stop-bit checker
// uses that pulse to flag framing errors. data_out and check_stop feed the
// checker's data and check_stop inputs directly.
//
// PARAMETERS
// WIDTH       8   data bits per frame (1..16)
// OVERSAMPLE  16  baud_tick pulses per bit period (even, >= 4)
//
// PORTS
// clk         in   1      system clock
// rst         in   1      asynchronous active-low reset
// baud_tick   in   1      1-cycle pulse at OVERSAMPLE x baud rate
// RX_data     in   1      serial line, idles high, asynchronous to clk
// data_out    out  WIDTH  last received word, held until next frame completes
// check_stop  out  1      1-cycle pulse, registered, at mid stop bit
// data_valid  out  1      1-cycle pulse, same cycle as check_stop
// start_err   out  1      1-cycle pulse when a start bit is rejected as a glitch
// busy        out  1      high in every state except IDLE
//
// BEHAVIOUR
// - Reset (async, rst=0): state=IDLE, counters=0, shift reg=0. data_out=0,
//   check_stop=0, data_valid=0, start_err=0, busy=0. Synchronizer flops reset to 1.
// - RX_data passes through a 2-flop synchronizer: rx_s = RX_data delayed 2 clk.
//   All FSM decisions use rx_s.
// - The FSM advances only on cycles with baud_tick=1. No tick means all state holds.
// - tick_cnt has width clog2(OVERSAMPLE). bit_cnt has width clog2(WIDTH+1).
// - IDLE: on tick with rx_s=0, go to START with tick_cnt=0.
// - START: on each tick, tick_cnt++. When tick_cnt==OVERSAMPLE/2-1 (mid start bit):
//   - rx_s=0: go to DATA with tick_cnt=0, bit_cnt=0.
//   - rx_s=1: go to IDLE and pulse start_err on the next cycle.
// - DATA: on each tick, tick_cnt++. When tick_cnt==OVERSAMPLE-1 (mid data bit):
//   - shift right with rx_s entering the MSB, tick_cnt wraps to 0, bit_cnt++.
//   - When bit_cnt reaches WIDTH, go to STOP.
//   - The first bit received ends up in data_out[0].
// - STOP: on each tick, tick_cnt++. When tick_cnt==OVERSAMPLE-1 (mid stop bit):
//   - copy shift reg into data_out,
//   - assert check_stop=1 and data_valid=1 for exactly the next clk cycle,
//   - go to IDLE.
// - The controller does not judge the stop level; the stop checker does.
// - Latency: data_valid rises 1 clk after the mid-stop-bit tick. A new start
//   bit can be detected on the first tick after that.
// - Back-to-back frames: a start bit that immediately follows the stop bit is
//   accepted with no idle gap.
// - A line held low (break) is received as an all-zero word. The stop checker
//   flags it; the FSM then restarts from IDLE.
// - Reset asserted mid-frame: the partial word is discarded and no pulse is emitted.
//   data_out returns to 0.
// - check_stop, data_valid and start_err are never high for 2 consecutive cycles.
//
// TESTING
// 1. Frame 0xA5, OVERSAMPLE=16, tick every clk, valid stop bit
//    -> data_out=8'hA5; check_stop and data_valid high 1 cycle; busy drops the same cycle.
// 2. Low glitch of 4 ticks on an idle line
//    -> start_err pulses once; busy high for 8 ticks; no data_valid.
// 3. Frames 0x3C then 0xC3 back to back, no idle gap
//    -> two data_valid pulses, 10 bit periods apart, in order 3C then C3.
// 4. Frame 0x00 with stop bit driven low
//    -> check_stop pulses with RX_data=0 at that cycle; data_out=8'h00; FSM back in IDLE.
// 5. rst=0 asserted during data bit 4, then line idle
//    -> all outputs 0 immediately. A following 0x5A frame is received correctly.
// 6. baud_tick every 3 clk, frame 0xFF
//    -> data_out=8'hFF; data_valid is exactly 1 clk wide.

Source files
------------

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: synchronises the serial line, finds the start bit, samples
// WIDTH data bits LSB first at mid bit and pulses check_stop/data_valid at mid stop bit.
module uart_rx_controller #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             baud_tick,
    input  logic             RX_data,
    output logic [WIDTH-1:0] data_out,
    output logic             check_stop,
    output logic             data_valid,
    output logic             start_err,
    output logic             busy
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(WIDTH + 1);

    localparam logic [TickW-1:0] TickMid = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickEnd = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitEnd  = BitW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // Two-flop synchroniser; resets to the idle line level.
    logic rx_meta_q, rx_s_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX_data;
            rx_s_q    <= rx_meta_q;
        end
    end

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             check_q, check_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        check_d = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (baud_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_d = StStart;
                        tick_d  = '0;
                    end
                end
                StStart: begin
                    if (tick_q == TickMid) begin
                        tick_d = '0;
                        if (!rx_s_q) begin
                            state_d = StData;
                            bit_d   = '0;
                        end else begin
                            // Line went back high before mid start bit: treat as a glitch.
                            state_d = StIdle;
                            err_d   = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StData: begin
                    if (tick_q == TickEnd) begin
                        tick_d  = '0;
                        shift_d = WIDTH'({rx_s_q, shift_q} >> 1);
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BitEnd) begin
                            state_d = StStop;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StStop: begin
                    if (tick_q == TickEnd) begin
                        tick_d  = '0;
                        data_d  = shift_q;
                        check_d = 1'b1;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            check_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            check_q <= check_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_out   = data_q;
    assign check_stop = check_q;
    assign data_valid = valid_q;
    assign start_err  = err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: table of frames plus hand sequences for the
// start-bit glitch and the mid-frame reset.
module tb_uart_rx_controller;

    localparam int OS = 16;
    localparam int NV = 5;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       baud_tick = 1'b0;
    logic       RX_data   = 1'b1;
    logic [7:0] data_out;
    logic       check_stop;
    logic       data_valid;
    logic       start_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_controller #(
        .WIDTH      (8),
        .OVERSAMPLE (OS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .RX_data    (RX_data),
        .data_out   (data_out),
        .check_stop (check_stop),
        .data_valid (data_valid),
        .start_err  (start_err),
        .busy       (busy)
    );

    int ntests = 0;
    int nfail  = 0;
    int div    = 1;

    // Output monitor, sampled on the falling edge.
    int   vdata[$];
    int   vcyc[$];
    int   cyc      = 0;
    int   n_err    = 0;
    int   n_busy   = 0;
    int   bad_pair = 0;
    int   bad_busy = 0;
    int   bad_run  = 0;
    int   rx_chk   = -1;
    logic pv = 1'b0, pc = 1'b0, pe = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (data_valid) begin
            vdata.push_back(int'(data_out));
            vcyc.push_back(cyc);
        end
        if (check_stop) rx_chk <= int'(RX_data);
        if (start_err) n_err <= n_err + 1;
        if (busy) n_busy <= n_busy + 1;
        if (data_valid != check_stop) bad_pair <= bad_pair + 1;
        if (check_stop && busy) bad_busy <= bad_busy + 1;
        if ((data_valid && pv) || (check_stop && pc) || (start_err && pe)) bad_run <= bad_run + 1;
        pv <= data_valid;
        pc <= check_stop;
        pe <= start_err;
    end

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int getd(input int i);
        if (i < vdata.size()) return vdata[i];
        return -1;
    endfunction

    function automatic int getc(input int i);
        if (i < vcyc.size()) return vcyc[i];
        return -1;
    endfunction

    // Each tick: baud_tick high for one clk, then div-1 idle clks. Inputs change 2ns after posedge.
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            baud_tick = 1'b1;
            @(posedge clk); #2;
            baud_tick = 1'b0;
            for (int j = 1; j < div; j++) begin
                @(posedge clk); #2;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        RX_data = 1'b0;
        do_ticks(OS);
        for (int b = 0; b < 8; b++) begin
            RX_data = d[b];
            do_ticks(OS);
        end
        RX_data = stop;
        do_ticks(OS);
    endtask

    typedef struct {
        int         nfr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       stop;
        int         div;
        int         exp_valid;
        int         exp_err;
        int         exp_first;
        int         exp_last;
        int         exp_rx;
        int         exp_gap;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        int base, e0, r0, p0, b0, bz0;

        vecs[0] = '{1, 8'hA5, 8'h00, 1'b1, 1, 1, 0, 'hA5, 'hA5, 1, 0};
        vecs[1] = '{2, 8'h3C, 8'hC3, 1'b1, 1, 2, 0, 'h3C, 'hC3, 1, 160};
        // Stop held low: the still-low line right after the frame restarts a start bit
        // that is then rejected as a glitch once the line returns high.
        vecs[2] = '{1, 8'h00, 8'h00, 1'b0, 1, 1, 1, 'h00, 'h00, 0, 0};
        vecs[3] = '{1, 8'hFF, 8'h00, 1'b1, 3, 1, 0, 'hFF, 'hFF, 1, 0};
        vecs[4] = '{2, 8'h81, 8'h7E, 1'b1, 2, 2, 0, 'h81, 'h7E, 1, 320};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("reset data_out", int'(data_out), 0);
        chk("reset check_stop", int'(check_stop), 0);
        chk("reset data_valid", int'(data_valid), 0);
        chk("reset start_err", int'(start_err), 0);
        chk("reset busy", int'(busy), 0);
        rst = 1'b1;
        div = 1;
        do_ticks(10);

        for (int v = 0; v < NV; v++) begin
            div  = vecs[v].div;
            base = vdata.size();
            e0   = n_err;
            r0   = bad_run;
            p0   = bad_pair;
            b0   = bad_busy;
            send_frame(vecs[v].d0, (vecs[v].nfr == 2) ? 1'b1 : vecs[v].stop);
            if (vecs[v].nfr == 2) send_frame(vecs[v].d1, vecs[v].stop);
            RX_data = 1'b1;
            do_ticks(40);
            chk($sformatf("v%0d valid count", v), vdata.size() - base, vecs[v].exp_valid);
            chk($sformatf("v%0d start_err count", v), n_err - e0, vecs[v].exp_err);
            chk($sformatf("v%0d first word", v), getd(base), vecs[v].exp_first);
            chk($sformatf("v%0d last word", v), getd(base + vecs[v].exp_valid - 1),
                vecs[v].exp_last);
            chk($sformatf("v%0d rx at check_stop", v), rx_chk, vecs[v].exp_rx);
            if (vecs[v].nfr == 2)
                chk($sformatf("v%0d valid spacing", v), getc(base + 1) - getc(base),
                    vecs[v].exp_gap);
            chk($sformatf("v%0d data_out held", v), int'(data_out), vecs[v].exp_last);
            chk($sformatf("v%0d busy idle", v), int'(busy), 0);
            chk($sformatf("v%0d pulse width", v), bad_run - r0, 0);
            chk($sformatf("v%0d valid/check pairing", v), bad_pair - p0, 0);
            chk($sformatf("v%0d busy at check_stop", v), bad_busy - b0, 0);
        end

        // Low glitch of 4 ticks on an idle line
        div  = 1;
        base = vdata.size();
        e0   = n_err;
        bz0  = n_busy;
        RX_data = 1'b0;
        do_ticks(4);
        RX_data = 1'b1;
        do_ticks(40);
        chk("glitch start_err count", n_err - e0, 1);
        chk("glitch busy cycles", n_busy - bz0, 8);
        chk("glitch valid count", vdata.size() - base, 0);

        // Reset asserted during data bit 4, then a clean 0x5A frame
        base = vdata.size();
        RX_data = 1'b0;
        do_ticks(OS);
        for (int b = 0; b < 4; b++) begin
            RX_data = b[0];
            do_ticks(OS);
        end
        RX_data = 1'b0;
        do_ticks(8);
        chk("pre-reset busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("mid-reset data_out", int'(data_out), 0);
        chk("mid-reset busy", int'(busy), 0);
        chk("mid-reset check_stop", int'(check_stop), 0);
        chk("mid-reset data_valid", int'(data_valid), 0);
        chk("mid-reset start_err", int'(start_err), 0);
        RX_data = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        do_ticks(20);
        chk("post-reset no pulse", vdata.size() - base, 0);
        send_frame(8'h5A, 1'b1);
        do_ticks(40);
        chk("post-reset valid count", vdata.size() - base, 1);
        chk("post-reset word", getd(base), 'h5A);
        chk("post-reset data_out", int'(data_out), 'h5A);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
